// File: rtl/sram_1kx1_bank_ctl_if.sv
// Request/ack ports for the two requesters plus the strobes of the 1Kx1 SRAM bank.
// "master" is the requester/RAM side; "slave" is the bank controller.
interface sram_1kx1_bank_ctl_if #(
    parameter int WIDTH = 32
);
    logic             req0, req1;
    logic             we0, we1;
    logic [9:0]       addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             ack0, ack1;
    logic [WIDTH-1:0] rdata;
    logic [9:0]       ram_a;
    logic [WIDTH-1:0] ram_di;
    logic [WIDTH-1:0] ram_do;
    logic             ram_ce_n;
    logic             ram_we_n;
    logic             busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_do,
        input  ack0, ack1, rdata, ram_a, ram_di, ram_ce_n, ram_we_n, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_do,
        output ack0, ack1, rdata, ram_a, ram_di, ram_ce_n, ram_we_n, busy
    );
endinterface

// File: rtl/sram_1kx1_bank_ctl.sv
// Two-port round-robin sequencer for a bank of WIDTH 1Kx1 SRAMs: orders chip-enable and
// write-enable around each access so address/data have setup and hold around the write pulse.
module sram_1kx1_bank_ctl #(
    parameter int WIDTH       = 32,
    parameter int READ_CYCLES = 2,
    parameter int WE_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_1kx1_bank_ctl_if.slave  bus
);
    localparam int CMAX = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

    typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [9:0]       a_q, a_d;
    logic [WIDTH-1:0] di_q, di_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ce_n_q, ce_n_d;
    logic             we_n_q, we_n_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             elig0, elig1, pick1, op_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            di_q    <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            a_q     <= a_d;
            di_q    <= di_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        a_d     = a_q;
        di_d    = di_q;
        rdata_d = rdata_q;
        ce_n_d  = ce_n_q;
        we_n_d  = we_n_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        // A port whose ack is high this cycle is still showing its old request.
        elig0   = bus.req0 & ~ack0_q;
        elig1   = bus.req1 & ~ack1_q;
        pick1   = elig1 & (~elig0 | ~last_q);
        op_we   = pick1 ? bus.we1 : bus.we0;

        unique case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    gnt_d  = pick1;
                    last_d = pick1;
                    a_d    = pick1 ? bus.addr1 : bus.addr0;
                    di_d   = pick1 ? bus.wdata1 : bus.wdata0;
                    ce_n_d = 1'b0;
                    if (op_we) begin
                        state_d = WSETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = CW'(READ_CYCLES - 1);
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.ram_do;
                    ce_n_d  = 1'b1;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WSETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CW'(WE_CYCLES - 1);
                state_d = WPULSE;
            end
            WPULSE: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = WHOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WHOLD: begin
                ce_n_d  = 1'b1;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata    = rdata_q;
    assign bus.ram_a    = a_q;
    assign bus.ram_di   = di_q;
    assign bus.ram_ce_n = ce_n_q;
    assign bus.ram_we_n = we_n_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sram_1kx1_bank_ctl.sv
// Directed bench: default-parameter controller plus a READ_CYCLES=1 / WE_CYCLES=4 instance,
// each driving a behavioural 1Kx32 RAM.
module tb_sram_1kx1_bank_ctl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   viol  = 0;
    logic [40:0] ce_h, we_h;

    always #5 clk = ~clk;

    sram_1kx1_bank_ctl_if #(.WIDTH(W)) b ();
    sram_1kx1_bank_ctl_if #(.WIDTH(W)) b2 ();

    sram_1kx1_bank_ctl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(b.slave));
    sram_1kx1_bank_ctl #(.WIDTH(W), .READ_CYCLES(1), .WE_CYCLES(4)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave));

    logic [W-1:0] mem  [1024];
    logic [W-1:0] mem2 [1024];

    always @(posedge clk) begin
        if (!b.ram_ce_n && !b.ram_we_n)   mem[b.ram_a]   <= b.ram_di;
        if (!b2.ram_ce_n && !b2.ram_we_n) mem2[b2.ram_a] <= b2.ram_di;
    end
    assign b.ram_do  = b.ram_ce_n  ? '0 : mem[b.ram_a];
    assign b2.ram_do = b2.ram_ce_n ? '0 : mem2[b2.ram_a];

    // Strobe-ordering watch on the default instance.
    logic       prev_we = 1'b1;
    logic [9:0] prev_a  = '0;
    always @(negedge clk) begin
        if (!b.ram_we_n && b.ram_ce_n) viol <= viol + 1;
        if (prev_we && !b.ram_we_n && (b.ram_a != prev_a)) viol <= viol + 1;
        prev_we <= b.ram_we_n;
        prev_a  <= b.ram_a;
    end

    wire         ack0_s  = sel ? b2.ack0     : b.ack0;
    wire         ack1_s  = sel ? b2.ack1     : b.ack1;
    wire         ce_s    = sel ? b2.ram_ce_n : b.ram_ce_n;
    wire         we_s    = sel ? b2.ram_we_n : b.ram_we_n;
    wire [W-1:0] rdata_s = sel ? b2.rdata    : b.rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit w, input logic [9:0] a,
                           input logic [W-1:0] d);
        if (!sel) begin
            if (!p) begin b.req0 = v; b.we0 = w; b.addr0 = a; b.wdata0 = d; end
            else    begin b.req1 = v; b.we1 = w; b.addr1 = a; b.wdata1 = d; end
        end else begin
            if (!p) begin b2.req0 = v; b2.we0 = w; b2.addr0 = a; b2.wdata0 = d; end
            else    begin b2.req1 = v; b2.we1 = w; b2.addr1 = a; b2.wdata1 = d; end
        end
    endtask

    // lat = clocks from the sampling edge (k=1) to the edge that raises ack.
    task automatic do_op(input bit p, input bit w, input logic [9:0] a, input logic [W-1:0] d,
                         output int lat);
        @(negedge clk);
        set_req(p, 1'b1, w, a, d);
        lat  = 0;
        ce_h = '1;
        we_h = '1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            ce_h[k] = ce_s;
            we_h[k] = we_s;
            if (p ? ack1_s : ack0_s) lat = k;
        end
        @(negedge clk);
        set_req(p, 1'b0, w, a, d);
        if (lat == 0) chk("op_timeout", 64'd0, 64'd1);
    endtask

    int         lat;
    int         n;
    int         t   [4];
    logic [3:0] ord;
    logic [W-1:0] rd [4];
    int         acks;

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        b.req0 = 0; b.req1 = 0; b.we0 = 0; b.we1 = 0;
        b.addr0 = '0; b.addr1 = '0; b.wdata0 = '0; b.wdata1 = '0;
        b2.req0 = 0; b2.req1 = 0; b2.we0 = 0; b2.we1 = 0;
        b2.addr0 = '0; b2.addr1 = '0; b2.wdata0 = '0; b2.wdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        chk("rst_ce_n", b.ram_ce_n, 1);
        chk("rst_we_n", b.ram_we_n, 1);
        chk("rst_ram_a", b.ram_a, 0);
        chk("rst_ram_di", b.ram_di, 0);
        chk("rst_acks", {b.ack0, b.ack1}, 0);
        chk("rst_rdata", b.rdata, 0);
        chk("rst_busy", b.busy, 0);

        // single write then read
        do_op(0, 1, 10'h155, 32'hDEADBEEF, lat);
        chk("wr_lat", lat, 5);
        chk("wr_we_pat", we_h[5:1], 5'b11001);
        chk("wr_ce_pat", ce_h[5:1], 5'b10000);
        @(posedge clk); #1;
        chk("ack_pulse", ack0_s, 0);
        do_op(0, 0, 10'h155, '0, lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", rdata_s, 32'hDEADBEEF);

        // address extremes
        do_op(1, 1, 10'h3FF, 32'hA5A50001, lat);
        chk("wr3ff_lat", lat, 5);
        do_op(0, 1, 10'h000, 32'h5A5A0002, lat);
        chk("rdata_kept_on_wr", rdata_s, 32'hDEADBEEF);
        do_op(1, 0, 10'h3FF, '0, lat);
        chk("rd3ff_data", rdata_s, 32'hA5A50001);
        do_op(0, 0, 10'h000, '0, lat);
        chk("rd000_data", rdata_s, 32'h5A5A0002);

        // simultaneous reads straight after reset
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        set_req(0, 1, 0, 10'h3FF, '0);
        set_req(1, 1, 0, 10'h000, '0);
        n = 0;
        ord = '0;
        for (int c = 1; c <= 60 && n < 4; c++) begin
            @(posedge clk); #1;
            if (ack0_s || ack1_s) begin
                ord[n] = ack1_s;
                t[n]   = c;
                rd[n]  = rdata_s;
                n++;
            end
        end
        @(negedge clk);
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        chk("rr_count", n, 4);
        chk("rr_order", ord, 4'b1010);
        chk("rr_gap", t[1] - t[0], 3);
        chk("rr_rd0", rd[0], 32'hA5A50001);
        chk("rr_rd1", rd[1], 32'h5A5A0002);

        // stale request held across the ack cycle
        @(negedge clk);
        set_req(1, 1, 0, 10'h155, '0);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (b.ack1) lat = k;
        end
        chk("stale_lat", lat, 3);
        @(posedge clk); #1;
        chk("stale_busy", b.busy, 0);
        chk("stale_ce_n", b.ram_ce_n, 1);
        set_req(1, 0, 0, '0, '0);
        @(posedge clk); #1;
        chk("stale_busy2", b.busy, 0);
        chk("stale_rdata", b.rdata, 32'hDEADBEEF);

        // reset in the middle of the write pulse
        @(negedge clk);
        set_req(0, 1, 1, 10'h0AA, 32'h11112222);
        @(posedge clk);
        @(posedge clk); #1;
        chk("wp_entered", b.ram_we_n, 0);
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        chk("abort_we_n", b.ram_we_n, 1);
        chk("abort_ce_n", b.ram_ce_n, 1);
        chk("abort_busy", b.busy, 0);
        chk("abort_rdata", b.rdata, 0);
        @(negedge clk) reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            acks += int'(b.ack0) + int'(b.ack1);
        end
        chk("abort_no_ack", acks, 0);
        do_op(0, 0, 10'h155, '0, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rdata_s, 32'hDEADBEEF);

        // short read, long write pulse instance
        sel = 1'b1;
        do_op(0, 1, 10'h02A, 32'h12345678, lat);
        chk("p_wr_lat", lat, 7);
        chk("p_we_pat", we_h[7:1], 7'b1100001);
        do_op(0, 0, 10'h02A, '0, lat);
        chk("p_rd_lat", lat, 2);
        chk("p_rd_data", rdata_s, 32'h12345678);
        sel = 1'b0;

        @(negedge clk);
        chk("strobe_invariants", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
